ahblite_keypad_scanner: RTL
===========================

// Module: ahblite_keypad_scanner
// PURPOSE
//  Parametrised AHB-lite keypad controller. Scans a ROWS x COLS key matrix and debounces each key.
//  Press/release events go into a FIFO that the CPU reads over AHB. The block raises a level IRQ
//  for the NVIC and sits on one interconnect port. Supersedes single-row, column-only key interrupts.
// PARAMETERS
//  ROWS        4      matrix rows driven; 1..16
//  COLS        4      matrix columns sensed; 1..8; ROWS*COLS <= 128
//  SCAN_DIV    50000  HCLK cycles each row is held low before sampling; >= 4
//  DEBOUNCE    4      consecutive differing samples required to change a key's state; 1..15
//  FIFO_DEPTH  8      event FIFO entries; power of 2, 2..64
// PORTS
//  HCLK       in   1          system clock
//  HRESET     in   1          asynchronous, active-high reset
//  HSEL       in   1          AHB slave select
//  HADDR      in   32         AHB address; only [3:2] decoded
//  HTRANS     in   2          AHB transfer type; active when HTRANS[1]=1
//  HSIZE      in   3          AHB size; ignored, word access assumed by software
//  HWRITE     in   1          AHB write
//  HWDATA     in   32         AHB write data
//  HREADY     in   1          AHB ready in
//  HREADYOUT  out  1          constant 1 (zero wait state)
//  HRESP      out  1          constant 0 (OKAY)
//  HRDATA     out  32         AHB read data
//  row        out  ROWS       row drive, active low
//  col        in   COLS       column sense, active low, asynchronous; 2-flop synchronised inside
//  key_irq    out  1          level interrupt
// BEHAVIOUR
//  Reset values: row = all 1; key_irq = 0; HRDATA = 0; CTRL = 0; FIFO empty; key states = released;
//  debounce counts = 0; scan FSM in IDLE.
//  Registers (word offsets):
//   0x0 CTRL    RW  [0] EN, [1] IRQ_EN
//   0x4 STATUS  R   [0] EMPTY, [1] FULL, [2] OVF, [15:8] COUNT
//               W   writing 1 to bit 2 clears OVF
//   0x8 DATA    R   [8] VALID, [7] REL (1 = release, 0 = press), [6:0] key index = r*COLS + c
//               a read pops one entry; reading an empty FIFO returns 0 and does not pop
//   0xC         reads 0, writes ignored
//  AHB handling:
//   - Address phase is registered when HSEL & HTRANS[1] & HREADY.
//   - Writes take effect in the data-phase cycle.
//   - Read data is valid combinationally in the data phase.
//   - The DATA pop commits at the end of the data phase.
//  Scan FSM: IDLE -> DRIVE -> EVAL -> DRIVE ...
//   - IDLE: row = all 1. Go to DRIVE with r = 0 when EN = 1.
//   - DRIVE: row[r] = 0, all other rows = 1, for SCAN_DIV cycles. Latch the synchronised col on the last cycle.
//   - EVAL: one cycle per column, c = 0..COLS-1. row[r] stays low.
//       pressed sample == stored state: counter cleared.
//       otherwise: counter increments; when it reaches DEBOUNCE, state toggles, counter clears,
//       and an event {REL, idx} is pushed.
//   - After c = COLS-1: r = (r == ROWS-1) ? 0 : r+1, back to DRIVE (wrap-around).
//  At most one push per cycle, by construction of EVAL.
//  FIFO full on push: the event is dropped, OVF is set, and the key state still toggles.
//  Push and pop in the same cycle: both occur and COUNT is unchanged. This includes FULL: the push is accepted.
//  EN cleared mid-scan: FSM goes to IDLE next cycle, row = all 1, key states and counters cleared,
//  no events generated. FIFO contents and OVF are kept.
//  key_irq is registered: key_irq = IRQ_EN & (~EMPTY | OVF). One cycle of latency after the
//  condition changes.
//  HRESET asserted mid-operation: all state returns to the reset values immediately (asynchronous).
// STRUCTURE
//  keypad_pkg: register offsets, CTRL/STATUS/DATA bit positions, event width (8), FSM state encoding.
//  Sub-module keypad_event_fifo (WIDTH, DEPTH):
//   - synchronous, registered pointers, count output, full/empty flags
//   - simultaneous push and pop allowed when full
//  The top level holds the AHB slave, the scan FSM and the debounce array.
// TESTING (ROWS=4 COLS=4 SCAN_DIV=8 DEBOUNCE=2 FIFO_DEPTH=4)
//  1. Hold key r1,c2 low for 3 full scans, EN=1 -> exactly one DATA = 0x106; STATUS.COUNT = 1 before the read.
//  2. Release that key and hold released for 3 scans -> DATA = 0x186. A further DATA read returns 0x000 with no pop.
//  3. Generate 5 events with IRQ_EN=1 -> FULL=1, OVF=1, key_irq=1. Write STATUS 0x4 and drain 4 entries -> key_irq=0.
//  4. A 1-scan glitch on r3,c0 (shorter than DEBOUNCE) -> no event; FIFO stays EMPTY.
//  5. Clear EN during DRIVE of r2 -> row = 4'hF next cycle, FIFO contents intact. Re-enable -> scan restarts at r = 0.
//  6. FIFO full, CPU pops in the same cycle the FSM pushes -> COUNT stays 4, OVF stays 0, order preserved.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the AHB-lite keypad scanner: register map, field positions,
// event format and scan FSM encoding.
package keypad_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int DATA_VALID     = 8;
  localparam int DATA_REL       = 7;
  localparam int EVT_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_EVAL  = 2'd2
  } scan_state_e;

  function automatic logic [EVT_W-1:0] make_event(input logic rel, input logic [6:0] idx);
    logic [EVT_W-1:0] e;
    e           = {EVT_W{1'b0}};
    e[DATA_REL] = rel;
    e[6:0]      = idx;
    return e;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Key event FIFO: registered pointers and occupancy count; a push is accepted while full
// when a pop happens in the same cycle.
module keypad_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Next-state pointers and count
  always_comb begin
    do_pop_s  = pop & (count_q != {(AW+1){1'b0}});
    do_push_s = push & ((count_q != (AW+1)'(DEPTH)) | do_pop_s);
    wptr_d    = do_push_s ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = do_pop_s ? rptr_q + 1'b1 : rptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, qualified by the pointer state so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;

endmodule

// File: rtl/ahblite_keypad_scanner.sv
// AHB-lite keypad controller: row-scan FSM, per-key debounce counters and an event FIFO
// the CPU drains through the DATA register, with a level interrupt.
module ahblite_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic            HWRITE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [31:0]     HRDATA,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic            key_irq
);

  localparam int NK = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic              dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [1:0]        dp_addr_q, dp_addr_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d, key_irq_q, key_irq_d;
  logic [COLS-1:0]   col_s1_q, col_s2_q, col_lat_q, col_lat_d;
  scan_state_e       state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [DW-1:0]     div_q, div_d;
  logic [ROWS-1:0]   row_q, row_d;
  logic [NK-1:0]     key_state_q, key_state_d;
  logic [3:0]        cnt_q [NK];
  logic [3:0]        cnt_d [NK];
  logic [KW-1:0]     key_sel_s;
  logic [6:0]        key_idx_s;
  logic              pressed_s, wr_phase_s, rd_phase_s, push_s, pop_s;
  logic [EVT_W-1:0]  push_data_s, fifo_dout_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [FW-1:0]     fifo_count_s;
  logic              unused_s;

  assign unused_s  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:3]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign row       = row_q;
  assign key_irq   = key_irq_q;

  // AHB address-phase capture
  always_comb begin
    if (HREADY) begin
      dp_valid_d = HSEL & HTRANS[1];
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[3:2];
    end else begin
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_addr_d  = dp_addr_q;
    end
  end

  // Register writes, DATA pop, overflow flag and interrupt
  always_comb begin
    wr_phase_s = dp_valid_q & dp_write_q & HREADY;
    rd_phase_s = dp_valid_q & ~dp_write_q & HREADY;
    pop_s      = rd_phase_s & (dp_addr_q == ADDR_DATA) & ~fifo_empty_s;
    if (wr_phase_s && (dp_addr_q == ADDR_CTRL)) begin
      ctrl_d = HWDATA[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    // A dropped event in the same cycle as a clear leaves OVF set
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (wr_phase_s && (dp_addr_q == ADDR_STATUS) && HWDATA[STAT_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    key_irq_d = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty_s | ovf_q);
  end

  // Data-phase read mux
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        ADDR_CTRL: HRDATA[1:0] = ctrl_q;
        ADDR_STATUS: begin
          HRDATA[STAT_EMPTY]              = fifo_empty_s;
          HRDATA[STAT_FULL]               = fifo_full_s;
          HRDATA[STAT_OVF]                = ovf_q;
          HRDATA[STAT_COUNT_LSB +: 8]     = 8'(fifo_count_s);
        end
        ADDR_DATA: begin
          if (!fifo_empty_s) begin
            HRDATA[DATA_VALID]   = 1'b1;
            HRDATA[EVT_W-1:0]    = fifo_dout_s;
          end else begin
            HRDATA = 32'd0;
          end
        end
        default: HRDATA = 32'd0;
      endcase
    end else begin
      HRDATA = 32'd0;
    end
  end

  // Scan FSM and debounce array; the written EN value acts in the same cycle
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    div_d       = div_q;
    row_d       = row_q;
    col_lat_d   = col_lat_q;
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    push_s      = 1'b0;
    push_data_s = {EVT_W{1'b0}};
    key_sel_s   = KW'(int'(r_q) * COLS + int'(c_q));
    key_idx_s   = 7'(int'(r_q) * COLS + int'(c_q));
    pressed_s   = ~col_lat_q[c_q];
    if (!ctrl_d[CTRL_EN]) begin
      state_d     = S_IDLE;
      r_d         = {RW{1'b0}};
      c_d         = {CW{1'b0}};
      div_d       = {DW{1'b0}};
      row_d       = {ROWS{1'b1}};
      key_state_d = {NK{1'b0}};
      for (int k = 0; k < NK; k++) begin
        cnt_d[k] = 4'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DRIVE;
          r_d     = {RW{1'b0}};
          div_d   = {DW{1'b0}};
          row_d   = ~(ROWS'(1));
        end
        S_DRIVE: begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            col_lat_d = col_s2_q;
            c_d       = {CW{1'b0}};
            state_d   = S_EVAL;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_EVAL: begin
          if (pressed_s == key_state_q[key_sel_s]) begin
            cnt_d[key_sel_s] = 4'd0;
          end else if (cnt_q[key_sel_s] + 4'd1 == 4'(DEBOUNCE)) begin
            key_state_d[key_sel_s] = pressed_s;
            cnt_d[key_sel_s]       = 4'd0;
            push_s                 = 1'b1;
            push_data_s            = make_event(key_state_q[key_sel_s], key_idx_s);
          end else begin
            cnt_d[key_sel_s] = cnt_q[key_sel_s] + 4'd1;
          end
          if (c_q == CW'(COLS - 1)) begin
            if (r_q == RW'(ROWS - 1)) begin
              r_d = {RW{1'b0}};
            end else begin
              r_d = r_q + 1'b1;
            end
            c_d     = {CW{1'b0}};
            div_d   = {DW{1'b0}};
            state_d = S_DRIVE;
            row_d   = ~(ROWS'(1) << r_d);
          end else begin
            c_d = c_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          row_d   = {ROWS{1'b1}};
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= 2'd0;
      ctrl_q      <= 2'd0;
      ovf_q       <= 1'b0;
      key_irq_q   <= 1'b0;
      col_s1_q    <= {COLS{1'b1}};
      col_s2_q    <= {COLS{1'b1}};
      col_lat_q   <= {COLS{1'b1}};
      state_q     <= S_IDLE;
      r_q         <= {RW{1'b0}};
      c_q         <= {CW{1'b0}};
      div_q       <= {DW{1'b0}};
      row_q       <= {ROWS{1'b1}};
      key_state_q <= {NK{1'b0}};
      for (int k = 0; k < NK; k++) begin
        cnt_q[k] <= 4'd0;
      end
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      key_irq_q   <= key_irq_d;
      col_s1_q    <= col;
      col_s2_q    <= col_s1_q;
      col_lat_q   <= col_lat_d;
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      div_q       <= div_d;
      row_q       <= row_d;
      key_state_q <= key_state_d;
      cnt_q       <= cnt_d;
    end
  end

  keypad_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_data_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule
